up_dn_counter_param: RTL and testbench

Parametrised up/down counter, the successor to the fixed 5-bit load/up/down counter. It adds configurable width and count range [MIN_VAL, MAX_VAL], a per-cycle step size, a run-time mode (saturate or wrap), synchronous reset, and one-cycle event pulses for wrap and saturation. It is a standalone building block for the mini-project library, used where a bounded event/position counter with limit flags is needed.

---
 rtl/up_dn_counter_param.sv | 108 ++++++++++
 tb/tb_up_dn_counter_param.sv | 134 +++++++++++++
 2 files changed

// File: rtl/up_dn_counter_param.sv
// rtl/up_dn_counter_param.sv - parametrised bounded up/down counter with saturate/wrap modes
module up_dn_counter_param #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 200,
    parameter int STEP_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  IN,
    input  logic              Load,
    input  logic              Up,
    input  logic              Down,
    input  logic [STEP_W-1:0] Step,
    input  logic              Mode,
    output logic [WIDTH-1:0]  Counter,
    output logic              High,
    output logic              Low,
    output logic              Wrap,
    output logic              Sat
);

    // Two guard bits keep Counter+Step and Counter+R-Step free of overflow.
    localparam int W2 = WIDTH + 2;

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [W2-1:0]    MIN_W = W2'(MIN_VAL);
    localparam logic [W2-1:0]    MAX_W = W2'(MAX_VAL);
    localparam logic [W2-1:0]    R_W   = W2'(MAX_VAL - MIN_VAL + 1);

    logic [W2-1:0]    cnt_w;
    logic [W2-1:0]    in_w;
    logic [W2-1:0]    step_w;
    logic [W2-1:0]    sum_up;
    logic [W2-1:0]    room_dn;
    logic             in_gt_max;
    logic             in_lt_min;
    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;

    assign cnt_w   = {2'b00, Counter};
    assign in_w    = {2'b00, IN};
    assign step_w  = W2'(Step);
    assign sum_up  = cnt_w + step_w;
    assign room_dn = cnt_w - MIN_W;

    assign in_gt_max = (in_w > MAX_W);
    // IN < MIN_VAL rewritten as IN + R <= MAX_VAL so it never degenerates
    // into an always-false compare against zero when MIN_VAL is 0.
    assign in_lt_min = ((in_w + R_W) <= MAX_W);

    // Next-state selection: load beats down beats up; no request holds.
    always_comb begin
        cnt_nxt  = Counter;
        wrap_nxt = 1'b0;
        sat_nxt  = 1'b0;
        if (Load) begin
            if (in_gt_max) begin
                cnt_nxt = MAX_C;
                sat_nxt = 1'b1;
            end else if (in_lt_min) begin
                cnt_nxt = MIN_C;
                sat_nxt = 1'b1;
            end else begin
                cnt_nxt = IN;
            end
        end else if (Down) begin
            if (room_dn >= step_w) begin
                cnt_nxt = WIDTH'(cnt_w - step_w);
            end else if (Mode) begin
                cnt_nxt  = WIDTH'(cnt_w + R_W - step_w);
                wrap_nxt = 1'b1;
            end else begin
                cnt_nxt = MIN_C;
                sat_nxt = 1'b1;
            end
        end else if (Up) begin
            if (sum_up <= MAX_W) begin
                cnt_nxt = WIDTH'(sum_up);
            end else if (Mode) begin
                cnt_nxt  = WIDTH'(sum_up - R_W);
                wrap_nxt = 1'b1;
            end else begin
                cnt_nxt = MAX_C;
                sat_nxt = 1'b1;
            end
        end
    end

    // Count register and one-cycle event pulses; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Counter <= MIN_C;
            Wrap    <= 1'b0;
            Sat     <= 1'b0;
        end else begin
            Counter <= cnt_nxt;
            Wrap    <= wrap_nxt;
            Sat     <= sat_nxt;
        end
    end

    assign High = (Counter == MAX_C);
    assign Low  = (Counter == MIN_C);

endmodule

// File: tb/tb_up_dn_counter_param.sv
// tb/tb_up_dn_counter_param.sv - directed self-checking bench for up_dn_counter_param
module tb_up_dn_counter_param;

    logic       clk = 1'b0;
    int         total = 0;
    int         bad   = 0;

    // Instance A: default parameters (8-bit, 0..200, 3-bit step)
    logic       a_rst, a_load, a_up, a_down, a_mode;
    logic [7:0] a_in;
    logic [2:0] a_step;
    logic [7:0] a_cnt;
    logic       a_high, a_low, a_wrap, a_sat;

    // Instance B: 5-bit, 3..31, 1-bit step
    logic       b_rst, b_load, b_up, b_down, b_mode;
    logic [4:0] b_in;
    logic [0:0] b_step;
    logic [4:0] b_cnt;
    logic       b_high, b_low, b_wrap, b_sat;

    always #5 clk = ~clk;

    up_dn_counter_param dut_a (
        .CLK(clk), .RST(a_rst), .IN(a_in), .Load(a_load), .Up(a_up), .Down(a_down),
        .Step(a_step), .Mode(a_mode), .Counter(a_cnt), .High(a_high), .Low(a_low),
        .Wrap(a_wrap), .Sat(a_sat)
    );

    up_dn_counter_param #(.WIDTH(5), .MIN_VAL(3), .MAX_VAL(31), .STEP_W(1)) dut_b (
        .CLK(clk), .RST(b_rst), .IN(b_in), .Load(b_load), .Up(b_up), .Down(b_down),
        .Step(b_step), .Mode(b_mode), .Counter(b_cnt), .High(b_high), .Low(b_low),
        .Wrap(b_wrap), .Sat(b_sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply one edge of stimulus to instance A, then sample just after the edge.
    task automatic drive_a(input logic rst, input logic ld, input logic up, input logic dn,
                           input logic [2:0] st, input logic md, input logic [7:0] val);
        @(negedge clk);
        a_rst = rst; a_load = ld; a_up = up; a_down = dn; a_step = st; a_mode = md; a_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic rst, input logic ld, input logic up, input logic dn,
                           input logic st, input logic md, input logic [4:0] val);
        @(negedge clk);
        b_rst = rst; b_load = ld; b_up = up; b_down = dn; b_step = st; b_mode = md; b_in = val;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int cnt, input int hi, input int lo,
                         input int wr, input int sa);
        chk({tag, ".cnt"},  int'(a_cnt),  cnt);
        chk({tag, ".high"}, int'(a_high), hi);
        chk({tag, ".low"},  int'(a_low),  lo);
        chk({tag, ".wrap"}, int'(a_wrap), wr);
        chk({tag, ".sat"},  int'(a_sat),  sa);
    endtask

    task automatic chk_b(input string tag, input int cnt, input int hi, input int lo,
                         input int wr, input int sa);
        chk({tag, ".cnt"},  int'(b_cnt),  cnt);
        chk({tag, ".high"}, int'(b_high), hi);
        chk({tag, ".low"},  int'(b_low),  lo);
        chk({tag, ".wrap"}, int'(b_wrap), wr);
        chk({tag, ".sat"},  int'(b_sat),  sa);
    endtask

    initial begin
        a_rst = 1'b0; a_load = 1'b0; a_up = 1'b0; a_down = 1'b0; a_step = 3'd0; a_mode = 1'b0; a_in = 8'd0;
        b_rst = 1'b0; b_load = 1'b0; b_up = 1'b0; b_down = 1'b0; b_step = 1'b0; b_mode = 1'b0; b_in = 5'd0;

        // reset and load
        drive_a(1, 0, 0, 0, 0, 0, 0);     chk_a("rst",      0,   0, 1, 0, 0);
        drive_a(0, 1, 0, 0, 0, 0, 13);    chk_a("ld13",     13,  0, 0, 0, 0);
        drive_a(0, 1, 0, 0, 0, 0, 250);   chk_a("ld250",    200, 1, 0, 0, 1);
        drive_a(0, 0, 0, 0, 0, 0, 0);     chk_a("idle",     200, 1, 0, 0, 0);

        // priority
        drive_a(0, 1, 0, 0, 0, 0, 13);    chk_a("ld13b",    13,  0, 0, 0, 0);
        drive_a(0, 0, 1, 1, 1, 0, 0);     chk_a("updn",     12,  0, 0, 0, 0);
        drive_a(0, 1, 1, 0, 1, 0, 5);     chk_a("ldup",     5,   0, 0, 0, 0);
        drive_a(1, 1, 0, 0, 0, 0, 7);     chk_a("rstld",    0,   0, 1, 0, 0);

        // saturate mode
        drive_a(0, 1, 0, 0, 0, 0, 198);   chk_a("ld198",    198, 0, 0, 0, 0);
        drive_a(0, 0, 1, 0, 3, 0, 0);     chk_a("satup",    200, 1, 0, 0, 1);
        drive_a(0, 0, 1, 0, 3, 0, 0);     chk_a("satup2",   200, 1, 0, 0, 1);
        drive_a(0, 1, 0, 0, 0, 0, 2);     chk_a("ld2",      2,   0, 0, 0, 0);
        drive_a(0, 0, 0, 1, 5, 0, 0);     chk_a("satdn",    0,   0, 1, 0, 1);

        // wrap mode
        drive_a(0, 1, 0, 0, 0, 1, 199);   chk_a("ld199",    199, 0, 0, 0, 0);
        drive_a(0, 0, 1, 0, 4, 1, 0);     chk_a("wrapup",   2,   0, 0, 1, 0);
        drive_a(0, 0, 0, 0, 0, 1, 0);     chk_a("wrapclr",  2,   0, 0, 0, 0);
        drive_a(0, 1, 0, 0, 0, 1, 1);     chk_a("ld1",      1,   0, 0, 0, 0);
        drive_a(0, 0, 0, 1, 3, 1, 0);     chk_a("wrapdn",   199, 0, 0, 1, 0);
        drive_a(0, 0, 1, 0, 1, 1, 0);     chk_a("up1",      200, 1, 0, 0, 0);
        drive_a(0, 0, 1, 0, 1, 1, 0);     chk_a("wrapmax",  0,   0, 1, 1, 0);
        drive_a(1, 0, 1, 0, 1, 1, 0);     chk_a("rstpulse", 0,   0, 1, 0, 0);

        // step sweep in saturate mode
        for (int i = 0; i < 28; i++) drive_a(0, 0, 1, 0, 7, 0, 0);
        chk_a("sweep28", 196, 0, 0, 0, 0);
        drive_a(0, 0, 1, 0, 7, 0, 0);     chk_a("sweep29",  200, 1, 0, 0, 1);
        drive_a(0, 0, 1, 0, 0, 0, 0);     chk_a("step0up",  200, 1, 0, 0, 0);
        drive_a(0, 0, 0, 1, 0, 1, 0);     chk_a("step0dn",  200, 1, 0, 0, 0);
        drive_a(0, 0, 0, 0, 0, 0, 0);

        // second parameter set
        drive_b(1, 0, 0, 0, 0, 0, 0);     chk_b("b.rst",    3,  0, 1, 0, 0);
        drive_b(0, 0, 0, 1, 1, 1, 0);     chk_b("b.wrapdn", 31, 1, 0, 1, 0);
        drive_b(0, 1, 0, 0, 0, 1, 0);     chk_b("b.ld0",    3,  0, 1, 0, 1);
        drive_b(0, 0, 0, 1, 1, 0, 0);     chk_b("b.satdn",  3,  0, 1, 0, 1);
        drive_b(0, 1, 0, 0, 0, 1, 31);    chk_b("b.ld31",   31, 1, 0, 0, 0);
        drive_b(0, 0, 1, 0, 1, 1, 0);     chk_b("b.wrapup", 3,  0, 1, 1, 0);
        drive_b(0, 0, 1, 0, 1, 0, 0);     chk_b("b.up",     4,  0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
